wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that owns the single write port of the general-purpose register file. It merges the in-order pipeline's writeback stream with results returned by multi-cycle units (divider, load unit) through a valid/ready handshake, buffers the multi-cycle results in a small FIFO, and keeps a per-register pending scoreboard that the issue stage uses to stall on outstanding multi-cycle destinations. Its registered outputs drive the register file's `waddr`/`we`/`wdata` inputs directly.

## Interface
- `ADDR_W`, 5: register address width; register count is 2^ADDR_W.
- `DATA_W`, 32: register data width.
- `DEPTH`, 2: multi-cycle result FIFO entries; must be a power of two, at least 2.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `pipe_we_i` in 1: pipeline writeback valid; always accepted, no backpressure.
- `pipe_waddr_i` in ADDR_W: pipeline destination register.
- `pipe_wdata_i` in DATA_W: pipeline result.
- `mc_valid_i` in 1: multi-cycle result valid.
- `mc_ready_o` out 1: FIFO can accept; transfer occurs when `mc_valid_i & mc_ready_o`.
- `mc_waddr_i` in ADDR_W: multi-cycle destination register.
- `mc_wdata_i` in DATA_W: multi-cycle result.
- `iss_valid_i` in 1: a multi-cycle op issues this cycle.
- `iss_waddr_i` in ADDR_W: destination of the issuing multi-cycle op.
- `pend_o` out 2^ADDR_W: bit r set while register r awaits a multi-cycle result.
- `we_o` out 1: register file write enable.
- `waddr_o` out ADDR_W: register file write address.
- `wdata_o` out DATA_W: register file write data.

## Operation
- FIFO: DEPTH entries of {addr, data}; binary read/write pointers plus a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
- `mc_ready_o` = (count != DEPTH), derived from registered state only. A pop in the same cycle does not raise `mc_ready_o`.
- Push: a handshake with `mc_waddr_i != 0` enqueues. A handshake with `mc_waddr_i == 0` completes but is discarded, with no enqueue.
- Per-cycle selection, in priority order:
  - `pipe_we_i & pipe_waddr_i != 0`: pipeline write is committed. The FIFO holds.
  - Otherwise, if the FIFO is not empty: the head is committed and popped.
  - Otherwise: no write; `we_o` goes to 0 next cycle.
- Pipeline writes to x0 are dropped and do not block a FIFO pop.
- Commit: on the clock edge, `we_o`/`waddr_o`/`wdata_o` load the selected write. When there is no write, `we_o` = 0 and `waddr_o`/`wdata_o` hold their previous values.
- Push and pop in the same cycle leave count unchanged. An empty FIFO never bypasses, so an incoming result is not written in the cycle it arrives.
- Scoreboard:
  - `iss_valid_i` with `iss_waddr_i != 0` sets bit `iss_waddr_i`.
  - A FIFO pop clears the bit of the popped address, on the same edge that loads `we_o`.
  - A set and a clear of the same bit in the same cycle: set wins, because a new op has been issued.
  - Bit 0 is constant 0.
- Ordering contract: the issue stage does not issue to a register whose `pend_o` bit is set. The pipeline does not write a pending register. The arbiter does not check either condition.
- No stalling of the pipeline: multi-cycle results are delayed for as long as the pipeline keeps writing.

## Timing
- Reset, asynchronous, effective immediately:
  - `we_o` = 0, `waddr_o` = 0, `wdata_o` = 0.
  - FIFO pointers and count = 0, so `mc_ready_o` = 1.
  - `pend_o` = all zeros.
- Pipeline path latency: 1 cycle. Input in cycle N appears on `we_o`/`waddr_o`/`wdata_o` in N+1, and the register file captures it at the end of N+1.
- Multi-cycle path latency:
  - Minimum 2 cycles, handshake at N and `we_o` at N+2, when there is no pipeline contention.
  - Each contending pipeline write adds 1 cycle.
- `pend_o` bit set: visible the cycle after issue.
- `pend_o` bit clear: falls in the same cycle `we_o` presents that register. The register file's write-through makes the new value readable in that cycle.
- Reset asserted mid-operation: FIFO contents and pending bits are lost, and no write is issued after reset. The owning pipeline is flushed by the same reset.
- Outputs only change on `clk` edges or `rst`.

## Test plan
- Reset then idle: `rst` pulse → `we_o` = 0, `waddr_o` = 0, `wdata_o` = 0, `mc_ready_o` = 1, `pend_o` = 0. With no inputs, outputs stay unchanged for 10 cycles.
- Pipeline stream: `pipe_we_i` = 1 to x5 = 0x11, then x6 = 0x22, on consecutive cycles → `we_o` = 1 with x5/0x11, then x6/0x22, each one cycle later. A pipeline write to x0 = 0xFF gives `we_o` = 0.
- Issue/return: issue x7 at cycle 0, then result x7 = 0xABCD handshaked at cycle 3 with the pipeline idle → `pend_o[7]` = 1 in cycles 1-4. At cycle 5, `we_o` = 1 with x7/0xABCD and `pend_o[7]` = 0.
- Contention and full: hold pipeline writes for 4 cycles while offering 3 mc results (x8, x9, x10) →
  - x8 and x9 are accepted.
  - `mc_ready_o` = 0 while full, and x10 waits.
  - After the pipeline idles, x8, x9 and x10 commit in order.
- Same-cycle set/clear: the pop of x12 coincides with a new issue to x12 → `we_o` writes x12 and `pend_o[12]` remains 1. The mc result to x0 is accepted and not written, and `pend_o[0]` stays 0.
- Async reset with 2 FIFO entries and pending bits set → immediately `we_o` = 0, `pend_o` = 0 and `mc_ready_o` = 1. No write appears after deassertion.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the register file write port. Pipeline writebacks take
// priority; multi-cycle results are queued in a small FIFO and drained when
// the pipeline is idle. A pending scoreboard tracks outstanding multi-cycle
// destinations for the issue stage.
module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_we_i,
  input  logic [ADDR_W-1:0]    pipe_waddr_i,
  input  logic [DATA_W-1:0]    pipe_wdata_i,
  input  logic                 mc_valid_i,
  output logic                 mc_ready_o,
  input  logic [ADDR_W-1:0]    mc_waddr_i,
  input  logic [DATA_W-1:0]    mc_wdata_i,
  input  logic                 iss_valid_i,
  input  logic [ADDR_W-1:0]    iss_waddr_i,
  output logic [2**ADDR_W-1:0] pend_o,
  output logic                 we_o,
  output logic [ADDR_W-1:0]    waddr_o,
  output logic [DATA_W-1:0]    wdata_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pend_q, pend_d;

  logic pipe_sel;
  logic push;
  logic pop;

  // Ready depends only on registered occupancy; a same-cycle pop does not help
  assign mc_ready_o = (cnt_q != CNT_W'(DEPTH));

  // Arbitration: non-x0 pipeline write wins, otherwise drain the FIFO head
  always_comb begin
    pipe_sel = pipe_we_i && (pipe_waddr_i != '0);
    push     = mc_valid_i && mc_ready_o && (mc_waddr_i != '0);
    pop      = !pipe_sel && (cnt_q != '0);
  end

  // FIFO pointer, count and storage update
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    if (push) begin
      fifo_addr_d[wptr_q] = mc_waddr_i;
      fifo_data_d[wptr_q] = mc_wdata_i;
      wptr_d              = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Commit selection; address/data hold when no write is made
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (pipe_sel) begin
      we_d    = 1'b1;
      waddr_d = pipe_waddr_i;
      wdata_d = pipe_wdata_i;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rptr_q];
      wdata_d = fifo_data_q[rptr_q];
    end
  end

  // Scoreboard: clear applied before set so a same-cycle reissue stays pending
  always_comb begin
    pend_d = pend_q;
    if (pop) begin
      pend_d[fifo_addr_q[rptr_q]] = 1'b0;
    end
    if (iss_valid_i) begin
      pend_d[iss_waddr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_addr_q <= '{default: '0};
      fifo_data_q <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      pend_q      <= '0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign pend_o  = pend_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 pipe_we_i = 1'b0;
  logic [ADDR_W-1:0]    pipe_waddr_i = '0;
  logic [DATA_W-1:0]    pipe_wdata_i = '0;
  logic                 mc_valid_i = 1'b0;
  logic                 mc_ready_o;
  logic [ADDR_W-1:0]    mc_waddr_i = '0;
  logic [DATA_W-1:0]    mc_wdata_i = '0;
  logic                 iss_valid_i = 1'b0;
  logic [ADDR_W-1:0]    iss_waddr_i = '0;
  logic [2**ADDR_W-1:0] pend_o;
  logic                 we_o;
  logic [ADDR_W-1:0]    waddr_o;
  logic [DATA_W-1:0]    wdata_o;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
    .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i),
    .iss_valid_i(iss_valid_i), .iss_waddr_i(iss_waddr_i),
    .pend_o(pend_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we_i = 1'b0; pipe_waddr_i = '0; pipe_wdata_i = '0;
    mc_valid_i = 1'b0; mc_waddr_i = '0; mc_wdata_i = '0;
    iss_valid_i = 1'b0; iss_waddr_i = '0;
  endtask

  task automatic pipe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pipe_we_i = 1'b1; pipe_waddr_i = a; pipe_wdata_i = d;
  endtask

  task automatic mc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mc_valid_i = 1'b1; mc_waddr_i = a; mc_wdata_i = d;
  endtask

  task automatic wr(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d);
    check({tag, "_we"}, 64'(we_o), 64'(we));
    check({tag, "_waddr"}, 64'(waddr_o), 64'(a));
    check({tag, "_wdata"}, 64'(wdata_o), 64'(d));
  endtask

  initial begin
    // Reset then idle
    #2 rst = 1'b1;
    #1;
    wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst_ready", 64'(mc_ready_o), 64'd1);
    check("rst_pend", 64'(pend_o), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      wr("idle", 1'b0, 5'd0, 32'h0);
      check("idle_pend", 64'(pend_o), 64'd0);
    end

    // Pipeline stream and x0 drop
    pipe(5'd5, 32'h11); tick(); wr("pipe5", 1'b1, 5'd5, 32'h11);
    pipe(5'd6, 32'h22); tick(); wr("pipe6", 1'b1, 5'd6, 32'h22);
    pipe(5'd0, 32'hFF); tick(); wr("pipe0", 1'b0, 5'd6, 32'h22);
    idle_inputs();

    // Issue x7, return at cycle 3, commit at cycle 5
    iss_valid_i = 1'b1; iss_waddr_i = 5'd7;
    tick(); idle_inputs();
    check("pend7_c1", 64'(pend_o[7]), 64'd1);
    tick(); check("pend7_c2", 64'(pend_o[7]), 64'd1);
    tick(); check("pend7_c3", 64'(pend_o[7]), 64'd1);
    check("ready_c3", 64'(mc_ready_o), 64'd1);
    mc(5'd7, 32'hABCD);
    tick(); idle_inputs();
    check("pend7_c4", 64'(pend_o[7]), 64'd1);
    check("we_c4", 64'(we_o), 64'd0);
    tick();
    wr("mc7", 1'b1, 5'd7, 32'hABCD);
    check("pend7_c5", 64'(pend_o[7]), 64'd0);

    // Contention: 4 pipeline writes while x8, x9, x10 are offered
    pipe(5'd1, 32'h101); mc(5'd8, 32'h808);
    check("ready_a0", 64'(mc_ready_o), 64'd1);
    tick(); wr("cont1", 1'b1, 5'd1, 32'h101);
    pipe(5'd2, 32'h102); mc(5'd9, 32'h909);
    check("ready_a1", 64'(mc_ready_o), 64'd1);
    tick(); wr("cont2", 1'b1, 5'd2, 32'h102);
    pipe(5'd3, 32'h103); mc(5'd10, 32'hA0A);
    check("ready_full_a2", 64'(mc_ready_o), 64'd0);
    tick(); wr("cont3", 1'b1, 5'd3, 32'h103);
    pipe(5'd4, 32'h104);
    check("ready_full_a3", 64'(mc_ready_o), 64'd0);
    tick(); wr("cont4", 1'b1, 5'd4, 32'h104);
    pipe_we_i = 1'b0; pipe_waddr_i = '0; pipe_wdata_i = '0;
    check("ready_full_a4", 64'(mc_ready_o), 64'd0);
    tick(); wr("drain8", 1'b1, 5'd8, 32'h808);
    check("ready_a5", 64'(mc_ready_o), 64'd1);
    tick(); idle_inputs();
    wr("drain9", 1'b1, 5'd9, 32'h909);
    tick(); wr("drain10", 1'b1, 5'd10, 32'hA0A);
    tick(); wr("drain_end", 1'b0, 5'd10, 32'hA0A);

    // Same-cycle set/clear on x12, plus a discarded result to x0
    iss_valid_i = 1'b1; iss_waddr_i = 5'd12;
    tick(); idle_inputs();
    check("pend12_set", 64'(pend_o[12]), 64'd1);
    mc(5'd12, 32'h1212);
    tick(); idle_inputs();
    mc(5'd0, 32'hDEAD);
    check("ready_x0", 64'(mc_ready_o), 64'd1);
    iss_valid_i = 1'b1; iss_waddr_i = 5'd12;
    tick(); idle_inputs();
    wr("mc12", 1'b1, 5'd12, 32'h1212);
    check("pend12_kept", 64'(pend_o[12]), 64'd1);
    check("pend0", 64'(pend_o[0]), 64'd0);
    tick();
    wr("x0_dropped", 1'b0, 5'd12, 32'h1212);
    check("pend_after_x0", 64'(pend_o), 64'h0000_1000);

    // Async reset with a full FIFO and pending bits
    pipe(5'd1, 32'h201); mc(5'd13, 32'hD0D);
    iss_valid_i = 1'b1; iss_waddr_i = 5'd14;
    tick(); iss_valid_i = 1'b0;
    pipe(5'd2, 32'h202); mc(5'd14, 32'hE0E);
    tick(); idle_inputs();
    check("pre_rst_ready", 64'(mc_ready_o), 64'd0);
    check("pre_rst_pend", 64'(pend_o), 64'h0000_5000);
    check("pre_rst_we", 64'(we_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    wr("async_rst", 1'b0, 5'd0, 32'h0);
    check("async_rst_pend", 64'(pend_o), 64'd0);
    check("async_rst_ready", 64'(mc_ready_o), 64'd1);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      wr("post_rst", 1'b0, 5'd0, 32'h0);
      check("post_rst_pend", 64'(pend_o), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
